wb_gpio_bank: RTL
=================

Name: wb_gpio_bank

Overview:
Parametrised Wishbone-slave GPIO bank for the user project area, sitting between the management SoC Wishbone port and a configurable slice of the user IO pads.
Generalises fixed pad hookup into software control:
- per-pin output data and output-enable
- synchronised input sampling
- atomic set/clear of outputs
- per-pin rising/falling edge capture with interrupt outputs

Parameters:
NUM_IO, 16, number of pads handled; legal 1..32; unused register bits read 0, writes ignored.
BASE_ADDR, 32'h3000_0000, byte base address of the register window; window is 256 bytes (decode on wbs_adr_i[31:8]).
SYNC_STAGES, 2, flip-flop stages on io_in before use; legal 2..4.

Ports:
wb_clk_i  input  1  single clock for all logic
wb_rst_i  input  1  reset, asynchronous, active-high
wbs_stb_i  input  1  Wishbone strobe
wbs_cyc_i  input  1  Wishbone cycle
wbs_we_i  input  1  write enable
wbs_sel_i  input  4  byte selects
wbs_adr_i  input  32  byte address
wbs_dat_i  input  32  write data
wbs_ack_o  output  1  acknowledge
wbs_dat_o  output  32  read data
io_in  input  NUM_IO  pad inputs
io_out  output  NUM_IO  pad output data
io_oeb  output  NUM_IO  pad output-enable, active-low
irq  output  3  interrupt lines

Behaviour:
Register map (offset = wbs_adr_i[7:0]):
- 0x00 OUT: RW, reset 0.
- 0x04 OEB: RW, reset all ones (all pads input).
- 0x08 IN: RO, synchronised input.
- 0x0C RISE_EN: RW, reset 0.
- 0x10 FALL_EN: RW, reset 0.
- 0x14 RISE_PEND: W1C, reset 0.
- 0x18 FALL_PEND: W1C, reset 0.
- 0x1C OUT_SET: W1S into OUT; reads 0.
- 0x20 OUT_CLR: W1C into OUT; reads 0.
- 0x24 ID: RO, {16'h6910, NUM_IO[15:0]}.
- Any other offset reads 0, writes ignored, still acked.

Byte selects apply to every write (RW, W1S, W1C): bits in unselected bytes are unaffected.

Wishbone handshake:
- Request = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & !wbs_ack_o.
- wbs_ack_o is registered: high exactly 1 cycle, in the cycle after a request. A held strobe therefore gets ack every other cycle.
- Write takes effect on the clock edge that raises ack.
- wbs_dat_o is valid while ack is high, and 0 otherwise.
- Address mismatch: no ack, no state change.

Pad outputs:
- io_out = OUT register.
- io_oeb = OEB register, driven directly from flops.

Input path:
- io_in passes through SYNC_STAGES flops (reset 0) to form sync_in.
- prev_in is a 1-cycle delay of sync_in (reset 0).
- IN reads sync_in, so read latency from a pad change is SYNC_STAGES cycles.

Edge capture:
- rise = sync_in & ~prev_in; fall = ~sync_in & prev_in.
- RISE_PEND[i] sets when rise[i] & RISE_EN[i]; FALL_PEND likewise with FALL_EN.
- Pending bits are set only while enabled. Disabling an enable does not clear the pending bit.
- Same cycle as a W1C of that bit: the new event wins and the bit stays 1.
- Overlapping events on a pin that is already pending are merged (no count).

Interrupts (registered, 1-cycle after the pending/enable change):
- irq[0] = |(RISE_PEND & RISE_EN)
- irq[1] = |(FALL_PEND & FALL_EN)
- irq[2] = 0

Reset:
- Asserting wb_rst_i at any time immediately clears ack, irq, and all registers (OEB to all ones).
- A transaction in flight is dropped without ack; the master must retry.

Test Plan:
- Reset with NUM_IO=16: io_oeb=16'hFFFF, io_out=0, irq=0, wbs_ack_o=0; read ID at BASE+0x24 -> 32'h6910_0010, ack exactly 1 cycle after strobe.
- Write OUT=32'h0000_A5A5 with sel=4'b0001 -> io_out=16'h00A5; then OUT_SET=16'h0F00 -> 16'h0FA5; then OUT_CLR=16'h0005 -> 16'h0FA0; reads of 0x1C/0x20 return 0.
- RISE_EN=1<<3, drive io_in[3] 0->1 -> RISE_PEND=16'h0008 and irq[0]=1 within SYNC_STAGES+2 cycles; W1C 16'h0008 -> irq[0]=0 next cycle.
- Fall event on pin 5 in the same cycle as a W1C to FALL_PEND[5] (FALL_EN[5]=1) -> FALL_PEND[5] remains 1, irq[1] stays 1.
- Strobe to address BASE+0x100 -> no ack for 8 cycles, no register change; read of offset 0x3C -> ack with data 0.
- Assert wb_rst_i asynchronously mid-write to OEB -> ack never rises, OEB=16'hFFFF; after release, a new write completes normally.

Source files
------------

// File: rtl/wb_gpio_bank.sv
// wb_gpio_bank: Wishbone-slave GPIO bank with atomic set/clear and edge-capture interrupts
module wb_gpio_bank #(
   parameter int          NUM_IO      = 16,
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
   parameter int          SYNC_STAGES = 2
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   input  logic [NUM_IO-1:0] io_in,
   output logic [NUM_IO-1:0] io_out,
   output logic [NUM_IO-1:0] io_oeb,
   output logic [2:0]        irq
);

   localparam logic [7:0] A_OUT   = 8'h00;
   localparam logic [7:0] A_OEB   = 8'h04;
   localparam logic [7:0] A_IN    = 8'h08;
   localparam logic [7:0] A_REN   = 8'h0C;
   localparam logic [7:0] A_FEN   = 8'h10;
   localparam logic [7:0] A_RPEND = 8'h14;
   localparam logic [7:0] A_FPEND = 8'h18;
   localparam logic [7:0] A_SET   = 8'h1C;
   localparam logic [7:0] A_CLR   = 8'h20;
   localparam logic [7:0] A_ID    = 8'h24;

   logic [NUM_IO-1:0] r_out, r_oeb, r_rise_en, r_fall_en, r_rise_pend, r_fall_pend, r_prev;
   logic [NUM_IO-1:0] r_sync [SYNC_STAGES];
   logic              r_ack;
   logic [31:0]       r_dat;
   logic [2:0]        r_irq;

   logic              w_req, w_wr;
   logic [7:0]        w_off;
   logic [31:0]       w_mask32, w_rdata;
   logic [NUM_IO-1:0] w_mask, w_wdat, w_in, w_rise, w_fall, w_rpend_clr, w_fpend_clr;
   logic              w_unused;

   assign w_req    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~r_ack;
   assign w_wr     = w_req & wbs_we_i;
   assign w_off    = wbs_adr_i[7:0];
   assign w_mask32 = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
   assign w_mask   = w_mask32[NUM_IO-1:0];
   assign w_wdat   = wbs_dat_i[NUM_IO-1:0] & w_mask;
   assign w_unused = ^{wbs_dat_i, w_mask32};

   assign w_in   = r_sync[SYNC_STAGES-1];
   assign w_rise = w_in & ~r_prev;
   assign w_fall = ~w_in & r_prev;

   assign w_rpend_clr = (w_wr && w_off == A_RPEND) ? w_wdat : '0;
   assign w_fpend_clr = (w_wr && w_off == A_FPEND) ? w_wdat : '0;

   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_dat;
   assign io_out    = r_out;
   assign io_oeb    = r_oeb;
   assign irq       = r_irq;

   // read-data mux; unmapped offsets and write-only strobes read as zero
   always_comb begin
      w_rdata = '0;
      case (w_off)
         A_OUT:   w_rdata = 32'(r_out);
         A_OEB:   w_rdata = 32'(r_oeb);
         A_IN:    w_rdata = 32'(w_in);
         A_REN:   w_rdata = 32'(r_rise_en);
         A_FEN:   w_rdata = 32'(r_fall_en);
         A_RPEND: w_rdata = 32'(r_rise_pend);
         A_FPEND: w_rdata = 32'(r_fall_pend);
         A_ID:    w_rdata = {16'h6910, 16'(NUM_IO)};
         default: w_rdata = '0;
      endcase
   end

   // single-cycle ack one clock after a request; data only visible while acked
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_ack <= 1'b0;
         r_dat <= '0;
      end else begin
         r_ack <= w_req;
         r_dat <= w_req ? w_rdata : '0;
      end
   end

   // input synchroniser chain plus one-cycle history for edge detection
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
         r_prev <= '0;
      end else begin
         r_sync[0] <= io_in;
         for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
         r_prev <= w_in;
      end
   end

   // OUT register: byte-masked plain write, atomic set and atomic clear
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) r_out <= '0;
      else r_out <= (w_wr && w_off == A_OUT) ? (r_out & ~w_mask) | w_wdat :
                    (w_wr && w_off == A_SET) ? r_out | w_wdat :
                    (w_wr && w_off == A_CLR) ? r_out & ~w_wdat : r_out;
   end

   // output-enable and edge-enable registers, byte-masked writes
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_oeb     <= '1;
         r_rise_en <= '0;
         r_fall_en <= '0;
      end else begin
         r_oeb     <= (w_wr && w_off == A_OEB) ? (r_oeb & ~w_mask) | w_wdat : r_oeb;
         r_rise_en <= (w_wr && w_off == A_REN) ? (r_rise_en & ~w_mask) | w_wdat : r_rise_en;
         r_fall_en <= (w_wr && w_off == A_FEN) ? (r_fall_en & ~w_mask) | w_wdat : r_fall_en;
      end
   end

   // pending bits: a fresh enabled edge overrides a simultaneous write-one-to-clear
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_rise_pend <= '0;
         r_fall_pend <= '0;
      end else begin
         r_rise_pend <= (r_rise_pend & ~w_rpend_clr) | (w_rise & r_rise_en);
         r_fall_pend <= (r_fall_pend & ~w_fpend_clr) | (w_fall & r_fall_en);
      end
   end

   // interrupt lines follow the enabled pending bits one cycle later
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) r_irq <= '0;
      else r_irq <= {1'b0, |(r_fall_pend & r_fall_en), |(r_rise_pend & r_rise_en)};
   end

endmodule
